// File: rtl/mdu_pkg.sv
// mdu_pkg: MDU opcode encodings, default latencies and FSM state type.
package mdu_pkg;
  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;
  localparam logic [3:0] MDU_MADD  = 4'd9;
  localparam logic [3:0] MDU_MADDU = 4'd10;
  localparam logic [3:0] MDU_MSUB  = 4'd11;
  localparam logic [3:0] MDU_MSUBU = 4'd12;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  typedef enum logic {S_IDLE, S_BUSY} mdu_state_e;
endpackage

// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit owning HI/LO, fixed multi-cycle latency.
//   clk, reset (sync, active-high); E_A/E_B operands; E_MDUOp opcode; E_Start launches
//   a mult/div-class op; E_Busy high while in flight; E_MDUOut returns HI/LO for mfhi/mflo.
//   Define MDU_MADD_EN to enable madd/maddu/msub/msubu (ops 9-12).
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic [3:0]  E_MDUOp,
  input  logic        E_Start,
  output logic        E_Busy,
  output logic [31:0] E_MDUOut
);
  localparam int CW = $clog2(MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1;
  mdu_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] tmp_q, tmp_d;
  logic [63:0] hilo, sprod, uprod, macc, res;
  logic [31:0] db, squo, srem, uquo, urem;
  logic signed [31:0] sa, sd;
  logic is_mul, is_div, is_macc, b_zero, start;
  assign hilo   = {hi_q, lo_q};
  assign is_mul = E_MDUOp == MDU_MULT || E_MDUOp == MDU_MULTU;
  assign is_div = E_MDUOp == MDU_DIV || E_MDUOp == MDU_DIVU;
  assign b_zero = E_B == 32'd0;
  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign sprod  = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
  assign uprod  = {32'd0, E_A} * {32'd0, E_B};
  // Divisor forced to 1 on zero so the datapath stays defined; the result is discarded.
  assign db     = b_zero ? 32'd1 : E_B;
  assign sa     = E_A;
  assign sd     = db;
  assign squo   = sa / sd;
  assign srem   = sa % sd;
  assign uquo   = E_A / db;
  assign urem   = E_A % db;
`ifdef MDU_MADD_EN
  assign is_macc = E_MDUOp >= MDU_MADD && E_MDUOp <= MDU_MSUBU;
  assign macc = E_MDUOp == MDU_MADD  ? hilo + sprod :
                E_MDUOp == MDU_MADDU ? hilo + uprod :
                E_MDUOp == MDU_MSUB  ? hilo - sprod : hilo - uprod;
`else
  assign is_macc = 1'b0;
  assign macc    = hilo;
`endif
  assign start  = state_q == S_IDLE && E_Start && (is_mul || is_div || is_macc);
  // Divide by zero reloads the current HI/LO so completion leaves them unchanged.
  assign res = E_MDUOp == MDU_MULT  ? sprod :
               E_MDUOp == MDU_MULTU ? uprod :
               E_MDUOp == MDU_DIV   ? (b_zero ? hilo : {srem, squo}) :
               E_MDUOp == MDU_DIVU  ? (b_zero ? hilo : {urem, uquo}) : macc;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmp_d   = tmp_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        tmp_d   = res;
        cnt_d   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        state_d = S_BUSY;
      end else if (!E_Start) begin
        hi_d = E_MDUOp == MDU_MTHI ? E_A : hi_q;
        lo_d = E_MDUOp == MDU_MTLO ? E_A : lo_q;
      end
    end else begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        {hi_d, lo_d} = tmp_q;
        state_d      = S_IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tmp_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmp_q   <= tmp_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  assign E_Busy   = state_q == S_BUSY;
  assign E_MDUOut = E_MDUOp == MDU_MFHI ? hi_q : E_MDUOp == MDU_MFLO ? lo_q : 32'd0;
endmodule
